store_rmw_unit: RTL and testbench

Store-path counterpart to the load sign-extension logic. It takes a store request (sb/sh/sw) from the MEM stage and writes it into a 32-bit-wide, word-addressed data memory that has no byte enables. Byte and halfword stores use a read-modify-write sequence; word stores write directly. It sits between the MEM-stage store request and the data memory port.

---
 rtl/store_rmw_unit.sv | 118 +++++++++++
 tb/tb_store_rmw_unit.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/store_rmw_unit.sv
// Store path into a word-wide data memory without byte enables: byte and half stores use
// read-modify-write, word stores write directly, misaligned or illegal sizes are rejected.
module store_rmw_unit #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_data,
  input  logic [1:0]        req_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [31:0]       mem_rd_data,
  output logic              mem_wr_en,
  output logic [31:0]       mem_wr_data,
  output logic              done,
  output logic              misaligned
);

  typedef enum logic [2:0] {StIdle, StRead, StMerge, StWrite, StErr} state_e;

  localparam logic [1:0] SizeByte = 2'b00;
  localparam logic [1:0] SizeHalf = 2'b01;
  localparam logic [1:0] SizeWord = 2'b10;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       data_q, data_d;
  logic [1:0]        size_q, size_d;
  logic [31:0]       wdata_q, wdata_d;

  logic        accept;
  logic        req_misaligned;
  logic [31:0] merged;

  assign accept = req_valid && (state_q == StIdle);

  always_comb begin
    req_misaligned = 1'b0;
    case (req_size)
      SizeByte: req_misaligned = 1'b0;
      SizeHalf: req_misaligned = req_addr[0];
      SizeWord: req_misaligned = (req_addr[1:0] != 2'b00);
      default:  req_misaligned = 1'b1;
    endcase
  end

  // Only the addressed lane(s) are replaced; the rest of the read word passes through.
  always_comb begin
    merged = mem_rd_data;
    case (size_q)
      SizeByte: merged[{addr_q[1:0], 3'b000} +: 8] = data_q[7:0];
      SizeHalf: merged[{addr_q[1], 4'b0000} +: 16] = data_q;
      default:  merged = mem_rd_data;
    endcase
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    size_d  = size_q;
    wdata_d = wdata_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          addr_d = req_addr;
          data_d = req_data[15:0];
          size_d = req_size;
          if (req_misaligned) begin
            state_d = StErr;
          end else if (req_size == SizeWord) begin
            wdata_d = req_data;
            state_d = StWrite;
          end else begin
            state_d = StRead;
          end
        end
      end
      StRead:  state_d = StMerge;
      StMerge: begin
        wdata_d = merged;
        state_d = StWrite;
      end
      StWrite: state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      data_q  <= '0;
      size_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      size_q  <= size_d;
      wdata_q <= wdata_d;
    end
  end

  // Strobes decode straight from the state register so an async reset drops them at once.
  assign req_ready   = (state_q == StIdle);
  assign mem_rd_en   = (state_q == StRead);
  assign mem_wr_en   = (state_q == StWrite);
  assign done        = (state_q == StWrite);
  assign misaligned  = (state_q == StErr);
  assign mem_addr    = {addr_q[ADDR_W-1:2], 2'b00};
  assign mem_wr_data = wdata_q;

endmodule

// File: tb/tb_store_rmw_unit.sv
// Bench for store_rmw_unit: directed scenarios then random stores against a byte-lane memory model.
module tb_store_rmw_unit;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic [31:0] req_data = '0;
  logic [1:0]  req_size = '0;
  logic [31:0] mem_addr;
  logic        mem_rd_en;
  logic [31:0] mem_rd_data = '0;
  logic        mem_wr_en;
  logic [31:0] mem_wr_data;
  logic        done;
  logic        misaligned;

  int errors = 0;
  int checks = 0;

  logic [31:0] tb_mem  [64];
  logic [31:0] ref_mem [64];

  int          o_rd_c, o_wr_c, o_dn_c, o_ms_c, o_rdy_c, o_rd_n, o_wr_n;
  bit          o_overlap;
  logic [31:0] o_wdata, o_waddr, o_raddr;

  store_rmw_unit #(.ADDR_W(32)) dut (
    .Clk         (Clk),
    .Rst         (Rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .req_size    (req_size),
    .mem_addr    (mem_addr),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_data (mem_rd_data),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_data (mem_wr_data),
    .done        (done),
    .misaligned  (misaligned)
  );

  always #5 Clk = ~Clk;

  // Synchronous-read data memory covering byte addresses 0x100..0x1FF.
  always @(posedge Clk) begin
    if (mem_rd_en) mem_rd_data <= tb_mem[int'(mem_addr[7:2])];
    if (mem_wr_en) tb_mem[int'(mem_addr[7:2])] = mem_wr_data;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_store(input logic [31:0] old, input logic [31:0] a,
                                            input logic [31:0] d, input logic [1:0] s);
    logic [7:0]  b [4];
    logic [31:0] r;
    for (int k = 0; k < 4; k++) b[k] = old[8*k +: 8];
    if (s == 2'd2) return d;
    if (s == 2'd0) b[int'(a[1:0])] = d[7:0];
    if (s == 2'd1) begin
      b[a[1] ? 2 : 0] = d[7:0];
      b[a[1] ? 3 : 1] = d[15:8];
    end
    for (int k = 0; k < 4; k++) r[8*k +: 8] = b[k];
    return r;
  endfunction

  function automatic bit ref_mis(input logic [31:0] a, input logic [1:0] s);
    return (s == 2'd3) || (s == 2'd1 && a[0]) || (s == 2'd2 && a[1:0] != 2'd0);
  endfunction

  task automatic set_word(input int i, input logic [31:0] v);
    tb_mem[i]  = v;
    ref_mem[i] = v;
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    int w = 0;
    @(negedge Clk);
    while (!req_ready && w < 20) begin
      @(negedge Clk);
      w++;
    end
    if (!req_ready) chk("ready_timeout", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_addr  = a;
    req_data  = d;
    req_size  = s;
    @(posedge Clk);
    #1 req_valid = 1'b0;
  endtask

  // Watches cycles 1..6 after the accept edge and records when each strobe first appears.
  task automatic observe();
    o_rd_c = -1; o_wr_c = -1; o_dn_c = -1; o_ms_c = -1; o_rdy_c = -1;
    o_rd_n = 0; o_wr_n = 0; o_overlap = 1'b0;
    o_wdata = 'x; o_waddr = 'x; o_raddr = 'x;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      @(negedge Clk);
      if (mem_rd_en) begin
        o_rd_n++;
        if (o_rd_c < 0) o_rd_c = cyc;
        o_raddr = mem_addr;
      end
      if (mem_wr_en) begin
        o_wr_n++;
        if (o_wr_c < 0) o_wr_c = cyc;
        o_wdata = mem_wr_data;
        o_waddr = mem_addr;
      end
      if (done && o_dn_c < 0) o_dn_c = cyc;
      if (misaligned && o_ms_c < 0) o_ms_c = cyc;
      if (req_ready && o_rdy_c < 0) o_rdy_c = cyc;
      if (mem_rd_en && mem_wr_en) o_overlap = 1'b1;
    end
  endtask

  task automatic run_txn(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    bit          mis;
    bit          rmw;
    int          i;
    logic [31:0] exp_word;
    mis = ref_mis(a, s);
    rmw = !mis && (s != 2'd2);
    i   = int'(a[7:2]);
    exp_word = mis ? ref_mem[i] : ref_store(ref_mem[i], a, d, s);
    issue(a, d, s);
    observe();
    chk("rd_cycle",    o_rd_c,  rmw ? 1 : -1);
    chk("rd_count",    o_rd_n,  rmw ? 1 : 0);
    chk("wr_cycle",    o_wr_c,  mis ? -1 : (rmw ? 3 : 1));
    chk("wr_count",    o_wr_n,  mis ? 0 : 1);
    chk("done_cycle",  o_dn_c,  mis ? -1 : (rmw ? 3 : 1));
    chk("mis_cycle",   o_ms_c,  mis ? 1 : -1);
    chk("ready_cycle", o_rdy_c, rmw ? 4 : 2);
    chk("rd_wr_overlap", 32'(o_overlap), 32'd0);
    if (!mis) begin
      chk("wr_data", o_wdata, exp_word);
      chk("wr_addr", o_waddr, {a[31:2], 2'b00});
      ref_mem[i] = exp_word;
    end
    if (rmw) chk("rd_addr", o_raddr, {a[31:2], 2'b00});
    chk("mem_word", tb_mem[i], ref_mem[i]);
  endtask

  initial begin
    int b2b_wr_c;
    int b2b_rdy;
    int wrs;
    for (int k = 0; k < 64; k++) set_word(k, $urandom);
    set_word(0, 32'h1122_3344);

    // Reset state while Rst is held.
    #3;
    chk("rst_ready",  32'(req_ready),  32'd1);
    chk("rst_rd_en",  32'(mem_rd_en),  32'd0);
    chk("rst_wr_en",  32'(mem_wr_en),  32'd0);
    chk("rst_done",   32'(done),       32'd0);
    chk("rst_mis",    32'(misaligned), 32'd0);
    chk("rst_addr",   mem_addr,        32'd0);
    chk("rst_wdata",  mem_wr_data,     32'd0);
    @(negedge Clk);
    @(negedge Clk);
    Rst = 1'b0;

    run_txn(32'h102, 32'hFFFF_FFAB, 2'd0);
    chk("sb_102_const", o_wdata, 32'h11AB_3344);
    set_word(0, 32'h1122_3344);

    run_txn(32'h102, 32'h1234_BEEF, 2'd1);
    chk("sh_102_const", o_wdata, 32'hBEEF_3344);
    run_txn(32'h100, 32'h0000_CAFE, 2'd1);
    chk("sh_100_const", o_wdata, 32'hBEEF_CAFE);

    run_txn(32'h104, 32'hDEAD_BEEF, 2'd2);
    chk("sw_104_const", o_wdata, 32'hDEAD_BEEF);

    run_txn(32'h101, 32'h0000_1234, 2'd1);
    run_txn(32'h106, 32'h5555_5555, 2'd2);
    run_txn(32'h100, 32'hAAAA_AAAA, 2'd3);

    // Reset asserted while the unit is in its merge cycle.
    set_word(0, 32'h1122_3344);
    issue(32'h103, 32'h0000_0055, 2'd0);
    @(negedge Clk);
    chk("abort_rd_en", 32'(mem_rd_en), 32'd1);
    @(negedge Clk);
    Rst = 1'b1;
    #1;
    chk("abort_wr_en", 32'(mem_wr_en), 32'd0);
    chk("abort_rd_en0", 32'(mem_rd_en), 32'd0);
    chk("abort_ready", 32'(req_ready), 32'd1);
    @(negedge Clk);
    Rst = 1'b0;
    wrs = 0;
    repeat (5) begin
      @(negedge Clk);
      if (mem_wr_en) wrs++;
    end
    chk("abort_no_wr", wrs, 0);
    chk("abort_mem", tb_mem[0], 32'h1122_3344);
    chk("abort_ready_after", 32'(req_ready), 32'd1);

    // Back-to-back: req_valid stays high across two byte stores.
    set_word(0, 32'h1122_3344);
    @(negedge Clk);
    req_valid = 1'b1;
    req_addr  = 32'h100;
    req_data  = 32'h11;
    req_size  = 2'd0;
    @(posedge Clk);
    #1;
    req_addr = 32'h101;
    req_data = 32'h22;
    b2b_wr_c = -1;
    b2b_rdy  = 0;
    for (int cyc = 1; cyc <= 4; cyc++) begin
      @(negedge Clk);
      if (mem_wr_en && b2b_wr_c < 0) b2b_wr_c = cyc;
      if (cyc == 4) b2b_rdy = int'(req_ready);
    end
    chk("b2b_first_wr", b2b_wr_c, 3);
    chk("b2b_ready_c4", b2b_rdy, 1);
    @(posedge Clk);
    #1 req_valid = 1'b0;
    observe();
    chk("b2b_second_rd", o_rd_c, 1);
    chk("b2b_second_wr", o_wr_c, 3);
    ref_mem[0] = ref_store(ref_store(ref_mem[0], 32'h100, 32'h11, 2'd0), 32'h101, 32'h22, 2'd0);
    chk("b2b_mem_model", tb_mem[0], ref_mem[0]);
    chk("b2b_mem_const", tb_mem[0], 32'h1122_2211);

    for (int n = 0; n < 150; n++) begin
      logic [31:0] ra;
      logic [1:0]  rs;
      ra = 32'h100 + 32'($urandom_range(0, 255));
      rs = 2'($urandom_range(0, 3));
      run_txn(ra, $urandom, rs);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
